// File: rtl/encoder_pipe.sv
// Registered MSB-priority N-to-log2(N) encoder with a 2-entry output FIFO.
// Build option: define ENCODER_ONEHOT_CHECK_EN to enable multi-hot detection (err, err_cnt).
module encoder_pipe #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] D,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Y,
    output logic         V,
    output logic         err,
    output logic [7:0]   err_cnt,
    output logic [1:0]   o_dbg_state
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic         r_in_ready;

    // Head entry drives the outputs directly; tail holds the second word.
    logic [W-1:0] r_head_y;
    logic         r_head_v;
    logic         r_head_err;
    logic [W-1:0] r_tail_y;
    logic         r_tail_v;
    logic         r_tail_err;

    logic         w_accept;
    logic         w_pop;
    logic         w_load_head_new;
    logic         w_load_head_tail;
    logic         w_load_tail;

    logic [W-1:0] w_y;
    logic         w_v;
    logic         w_err;

    // Handshake: a word transfers on a rising edge only when valid and ready
    // are both high; valid never waits on ready, and in_ready depends only on
    // registered state so there is no combinational path from out_ready.
    assign w_accept  = in_valid && r_in_ready;
    assign out_valid = (r_state != S_EMPTY);
    assign w_pop     = out_valid && out_ready;
    assign in_ready  = r_in_ready;

    always_comb begin
        w_y = '0;
        w_v = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (D[i]) begin
                w_y = W'(i);
                w_v = 1'b1;
            end
        end
    end

`ifdef ENCODER_ONEHOT_CHECK_EN
    logic [7:0] r_err_cnt;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_err = |(D & (D - N'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= 8'h00;
        end else if (w_accept && w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign w_err   = 1'b0;
    assign err_cnt = 8'h00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != S_TWO);
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_load_head_new  = 1'b0;
        w_load_head_tail = 1'b0;
        w_load_tail      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_next_state    = S_ONE;
                    w_load_head_new = 1'b1;
                end
            end
            S_ONE: begin
                if (w_accept && w_pop) begin
                    w_load_head_new = 1'b1;
                end else if (w_accept) begin
                    w_next_state = S_TWO;
                    w_load_tail  = 1'b1;
                end else if (w_pop) begin
                    w_next_state = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_pop) begin
                    w_next_state     = S_ONE;
                    w_load_head_tail = 1'b1;
                end
            end
            default: begin
                w_next_state = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_y   <= '0;
            r_head_v   <= 1'b0;
            r_head_err <= 1'b0;
            r_tail_y   <= '0;
            r_tail_v   <= 1'b0;
            r_tail_err <= 1'b0;
        end else begin
            if (w_load_head_new) begin
                r_head_y   <= w_y;
                r_head_v   <= w_v;
                r_head_err <= w_err;
            end else if (w_load_head_tail) begin
                r_head_y   <= r_tail_y;
                r_head_v   <= r_tail_v;
                r_head_err <= r_tail_err;
            end
            if (w_load_tail) begin
                r_tail_y   <= w_y;
                r_tail_v   <= w_v;
                r_tail_err <= w_err;
            end
        end
    end

    assign Y           = r_head_y;
    assign V           = r_head_v;
    assign err         = r_head_err;
    assign o_dbg_state = r_state;

endmodule
